apb_master_arbiter: RTL and testbench
=====================================

# apb_master_arbiter

Round-robin arbiter that shares the single APB master's internal request interface (transfer/ready/addr/wdata/write/rdata) between NUM_REQ requesters, e.g. the CPU data port and a DMA engine. It sits directly in front of the APB master. It latches the winning requester's command and drives the master through one complete SETUP/ACCESS transfer. It returns read data and a one-cycle acknowledge to that requester.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters, from 2 to 8.

Ports:
- PCLK  in  1  system clock, all logic on rising edge.
- PRESET  in  1  reset, asynchronous, active-high.
- s_req  in  NUM_REQ  per-requester request; held high with stable command until its ack.
- s_addr  in  NUM_REQ x 32  per-requester address.
- s_wdata  in  NUM_REQ x 32  per-requester write data.
- s_write  in  NUM_REQ  per-requester direction: 1 = write, 0 = read.
- s_ack  out  NUM_REQ  one-cycle completion pulse, one-hot.
- s_rdata  out  32  read data; valid in the s_ack cycle; shared by all requesters.
- m_transfer  out  1  trigger to the master.
- m_addr  out  32  address to the master.
- m_wdata  out  32  write data to the master.
- m_write  out  1  direction to the master.
- m_ready  in  1  slave ready, muxed by the master.
- m_rdata  in  32  read data, muxed by the master.
- grant  out  NUM_REQ  one-hot owner of the current transfer; 0 in IDLE.
- busy  out  1  high in every state except IDLE.

## Operation
- Reset values: state IDLE; all outputs 0, including m_addr, m_wdata and s_rdata; round-robin pointer set so that requester 0 has the highest priority.
- FSM states: IDLE, ISSUE, SETUP, ACCESS, RESP.
- IDLE: if any s_req bit is high, pick the winner round-robin, starting at the index after the last granted requester. At that edge:
  - latch the winner's s_addr/s_wdata/s_write into m_addr/m_wdata/m_write;
  - set grant to the winner;
  - go to ISSUE.
- ISSUE: m_transfer = 1 for exactly this cycle; go to SETUP.
- SETUP: mirrors the master's SETUP phase; m_ready is ignored; go to ACCESS.
- ACCESS: wait while m_ready = 0. When m_ready = 1:
  - capture m_rdata into s_rdata (for write transfers, too);
  - set s_ack[grant] for the next cycle;
  - advance the pointer past the granted requester;
  - go to RESP.
- RESP: s_ack is high for this one cycle; no arbitration takes place; grant is cleared; go to IDLE.
- The requester must drop s_req by the edge that ends its ack cycle. A req still high in the following IDLE is a new request.
- m_addr/m_wdata/m_write hold their last latched values until the next grant. s_rdata holds until the next capture.
- s_req changes outside IDLE have no effect. The latched command is immune to input changes after grant.
- No timeout: a slave that never asserts ready stalls the arbiter in ACCESS until reset.

## Timing
- Zero-wait slave, request sampled at the end of cycle 0:
  - ISSUE in cycle 1;
  - SETUP in cycle 2 (the master is in SETUP);
  - ACCESS in cycle 3 (the master is in ACCESS, m_ready = 1);
  - s_ack in cycle 4;
  - IDLE in cycle 5.
- Each slave wait cycle adds one cycle to this latency. Back-to-back transfers have a 5-cycle period.
- Simultaneous requests: exactly one grant; the others wait in order of rotating priority. No requester starves. With all requesters continuously requesting, grants rotate strictly 0, 1, …, NUM_REQ-1.
- PRESET mid-transfer: asynchronously forces all outputs and the pointer to their reset values. The master shares PRESET, so no partial transfer completes. A pending ack is lost.

## Structure
- Package apb_arb_pkg: typedef enum arb_state_e {IDLE, ISSUE, SETUP, ACCESS, RESP}; localparam ADDR_W = 32; localparam DATA_W = 32.
- Sub-module apb_rr_pick: combinational round-robin selector.
  - Inputs: req vector and last-grant pointer.
  - Outputs: one-hot winner and a valid flag.
- The FSM, command latches and pointer register live in the top module.

## Test plan
- Write, zero wait: s_req[0] with addr 0x1000_0004, wdata 0xDEAD_BEEF, write=1 -> m_transfer high only in cycle 1; m_addr = 0x1000_0004, m_wdata = 0xDEAD_BEEF, m_write = 1; s_ack[0] in cycle 4.
- Read with waits: s_req[1] with addr 0x1000_1000, write=0; m_ready delayed 3 cycles after ACCESS entry; m_rdata = 0x1234_5678 -> s_ack[1] in cycle 7 with s_rdata = 0x1234_5678.
- Tie after reset: s_req = 2'b11 in the same cycle -> requester 0 is acked in cycle 4; requester 1 is granted in cycle 5 and acked in cycle 9.
- Continuous contention: both requests held high for 6 transfers -> grant sequence is 0,1,0,1,0,1; each s_ack is exactly one cycle long.
- Early ready ignored: m_ready tied high throughout -> m_ready in SETUP is ignored; ack still arrives in cycle 4; exactly one m_transfer pulse per request.
- Reset in ACCESS: PRESET asserted while stalled in ACCESS -> all outputs are 0 immediately; after release, a request from requester 1 is served only after pending requester 0 (pointer reset).

Source files
------------

// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared types and helpers for the APB master arbiter
// Purpose: FSM state encoding, bus widths and a one-hot to index helper
//          used by the arbiter top and its round-robin selector.
// Ports:   none (package).
package apb_arb_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MAX_REQ = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETUP,
    ACCESS,
    RESP
  } arb_state_e;

  // Converts a one-hot vector (up to MAX_REQ wide, zero-padded) to its bit index.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// rtl/apb_rr_pick.sv - combinational round-robin selector
// Purpose: picks one requester, searching from the index after the last grant
//          and wrapping around.
// Ports:   req    - request vector
//          last   - index of the most recently granted requester
//          winner - one-hot selected requester (0 when no request)
//          valid  - at least one request is pending
module apb_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   last,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  // Two passes: first the indices above the last grant, then wrap to the
  // bottom. The first hit in this order is the round-robin winner.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[i] && (i > int'(last))) begin
        winner[i] = 1'b1;
        valid     = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[i] && (i <= int'(last))) begin
        winner[i] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin arbiter in front of an APB master
// Purpose: shares one APB master request interface between NUM_REQ requesters;
//          latches the winner's command, runs one SETUP/ACCESS transfer and
//          returns read data plus a one-cycle acknowledge.
// Ports:   PCLK, PRESET          - clock, asynchronous active-high reset
//          s_req/s_addr/s_wdata/s_write - per-requester command
//          s_ack, s_rdata        - per-requester ack pulse, shared read data
//          m_transfer/m_addr/m_wdata/m_write - command to the APB master
//          m_ready, m_rdata      - completion and read data from the master
//          grant, busy           - current owner, arbiter not idle
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                            PCLK,
  input  logic                            PRESET,
  input  logic [NUM_REQ-1:0]              s_req,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  s_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  s_wdata,
  input  logic [NUM_REQ-1:0]              s_write,
  output logic [NUM_REQ-1:0]              s_ack,
  output logic [DATA_W-1:0]               s_rdata,
  output logic                            m_transfer,
  output logic [ADDR_W-1:0]               m_addr,
  output logic [DATA_W-1:0]               m_wdata,
  output logic                            m_write,
  input  logic                            m_ready,
  input  logic [DATA_W-1:0]               m_rdata,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_e           state;
  logic [PTR_W-1:0]     last_ptr;
  logic [NUM_REQ-1:0]   win_oh;
  logic                 win_valid;
  logic [ADDR_W-1:0]    win_addr;
  logic [DATA_W-1:0]    win_wdata;
  logic                 win_write;
  logic [MAX_REQ-1:0]   grant_ext;

  apb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req    (s_req),
    .last   (last_ptr),
    .winner (win_oh),
    .valid  (win_valid)
  );

  // One-hot AND-OR mux of the winning requester's command.
  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        win_addr  = win_addr | s_addr[i];
        win_wdata = win_wdata | s_wdata[i];
        win_write = win_write | s_write[i];
      end
    end
  end

  always_comb begin
    grant_ext = '0;
    grant_ext[NUM_REQ-1:0] = grant;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      last_ptr   <= PTR_W'(NUM_REQ - 1);  // requester 0 searched first
      grant      <= '0;
      busy       <= 1'b0;
      m_transfer <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_write    <= 1'b0;
      s_ack      <= '0;
      s_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            m_addr     <= win_addr;
            m_wdata    <= win_wdata;
            m_write    <= win_write;
            grant      <= win_oh;
            m_transfer <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          m_transfer <= 1'b0;
          state      <= SETUP;
        end
        // The master is in its SETUP phase here, so m_ready means nothing yet.
        SETUP: begin
          state <= ACCESS;
        end
        ACCESS: begin
          if (m_ready) begin
            s_rdata  <= m_rdata;
            s_ack    <= grant;
            last_ptr <= PTR_W'(onehot_to_idx(grant_ext));
            state    <= RESP;
          end
        end
        RESP: begin
          s_ack <= '0;
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - directed self-checking bench for apb_master_arbiter
module tb_apb_master_arbiter;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic [1:0]        s_req;
  logic [1:0][31:0]  s_addr;
  logic [1:0][31:0]  s_wdata;
  logic [1:0]        s_write;
  logic [1:0]        s_ack;
  logic [31:0]       s_rdata;
  logic              m_transfer;
  logic [31:0]       m_addr;
  logic [31:0]       m_wdata;
  logic              m_write;
  logic              m_ready;
  logic [31:0]       m_rdata;
  logic [1:0]        grant;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  apb_master_arbiter #(.NUM_REQ(2)) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .s_req      (s_req),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_write    (s_write),
    .s_ack      (s_ack),
    .s_rdata    (s_rdata),
    .m_transfer (m_transfer),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_write    (m_write),
    .m_ready    (m_ready),
    .m_rdata    (m_rdata),
    .grant      (grant),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    s_req = '0; s_addr = '0; s_wdata = '0; s_write = '0;
    m_ready = 1'b0; m_rdata = '0;
    tick();
    checks++;
    if ({m_transfer, m_write, busy, s_ack, grant} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=0000000", {m_transfer, m_write, busy, s_ack, grant});
    end
    checks++;
    if (m_addr !== 32'h0) begin errors++; $display("FAIL reset_m_addr got=%h exp=0", m_addr); end
    checks++;
    if (m_wdata !== 32'h0) begin errors++; $display("FAIL reset_m_wdata got=%h exp=0", m_wdata); end
    checks++;
    if (s_rdata !== 32'h0) begin errors++; $display("FAIL reset_s_rdata got=%h exp=0", s_rdata); end
    tick();
    PRESET = 1'b0;
  endtask

  task automatic test_write_zero_wait();
    logic [1:0] exp_ack;
    tick();
    s_req = 2'b01; s_addr[0] = 32'h1000_0004; s_wdata[0] = 32'hDEAD_BEEF; s_write = 2'b01;
    for (int c = 1; c <= 5; c++) begin
      tick();
      m_ready = (c == 3);
      exp_ack = (c == 4) ? 2'b01 : 2'b00;
      checks++;
      if (m_transfer !== (c == 1)) begin
        errors++; $display("FAIL write_transfer c=%0d got=%b exp=%b", c, m_transfer, (c == 1));
      end
      checks++;
      if (s_ack !== exp_ack) begin
        errors++; $display("FAIL write_ack c=%0d got=%b exp=%b", c, s_ack, exp_ack);
      end
      checks++;
      if (busy !== (c <= 4)) begin
        errors++; $display("FAIL write_busy c=%0d got=%b exp=%b", c, busy, (c <= 4));
      end
      if (c == 1) begin
        checks++;
        if ({m_addr, m_wdata, m_write} !== {32'h1000_0004, 32'hDEAD_BEEF, 1'b1}) begin
          errors++; $display("FAIL write_cmd got=%h %h %b exp=10000004 deadbeef 1", m_addr, m_wdata, m_write);
        end
        checks++;
        if (grant !== 2'b01) begin errors++; $display("FAIL write_grant got=%b exp=01", grant); end
        s_addr[0] = 32'hFFFF_0000;  // must not reach the latched command
      end
      if (c == 3) begin
        checks++;
        if (m_addr !== 32'h1000_0004) begin
          errors++; $display("FAIL write_latch_hold got=%h exp=10000004", m_addr);
        end
      end
      if (c == 4) s_req = 2'b00;
    end
  endtask

  task automatic test_read_wait();
    logic [1:0] exp_ack;
    tick();
    s_req = 2'b10; s_addr[1] = 32'h1000_1000; s_write = 2'b00;
    for (int c = 1; c <= 8; c++) begin
      tick();
      m_ready = (c == 6);
      m_rdata = (c == 6) ? 32'h1234_5678 : 32'h5555_AAAA;
      exp_ack = (c == 7) ? 2'b10 : 2'b00;
      checks++;
      if (s_ack !== exp_ack) begin
        errors++; $display("FAIL read_ack c=%0d got=%b exp=%b", c, s_ack, exp_ack);
      end
      if (c == 1) begin
        checks++;
        if ({grant, m_addr, m_write} !== {2'b10, 32'h1000_1000, 1'b0}) begin
          errors++; $display("FAIL read_cmd got=%b %h %b exp=10 10001000 0", grant, m_addr, m_write);
        end
      end
      if (c == 7) begin
        checks++;
        if (s_rdata !== 32'h1234_5678) begin
          errors++; $display("FAIL read_rdata got=%h exp=12345678", s_rdata);
        end
        s_req = 2'b00;
      end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL read_idle got=%b exp=0", busy); end
  endtask

  // Shared by the tie-after-reset and post-reset scenarios: both requesters
  // raise requests together and requester 0 must win first.
  task automatic run_pair(input string tag);
    logic [1:0] exp_ack, exp_grant;
    s_req = 2'b11; s_addr[0] = 32'h3000_0000; s_addr[1] = 32'h3000_0100;
    s_write = 2'b00; m_ready = 1'b1; m_rdata = 32'hA0A0_A0A0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      exp_ack   = (c == 4) ? 2'b01 : (c == 9) ? 2'b10 : 2'b00;
      exp_grant = (c <= 4) ? 2'b01 : (c >= 6 && c <= 9) ? 2'b10 : 2'b00;
      checks++;
      if (s_ack !== exp_ack) begin
        errors++; $display("FAIL %s_ack c=%0d got=%b exp=%b", tag, c, s_ack, exp_ack);
      end
      checks++;
      if (grant !== exp_grant) begin
        errors++; $display("FAIL %s_grant c=%0d got=%b exp=%b", tag, c, grant, exp_grant);
      end
      if (c == 4) s_req = 2'b10;
      if (c == 9) s_req = 2'b00;
    end
  endtask

  task automatic test_tie_after_reset();
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    run_pair("tie");
    checks++;
    if (s_rdata !== 32'hA0A0_A0A0) begin
      errors++; $display("FAIL tie_rdata got=%h exp=a0a0a0a0", s_rdata);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_ack, exp_grant, who;
    tick();
    s_req = 2'b11; m_ready = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      who       = (((c / 5) % 2) == 0) ? 2'b01 : 2'b10;
      exp_ack   = ((c % 5) == 4) ? who : 2'b00;
      exp_grant = ((c % 5) == 0) ? 2'b00 : who;
      checks++;
      if (s_ack !== exp_ack) begin
        errors++; $display("FAIL contend_ack c=%0d got=%b exp=%b", c, s_ack, exp_ack);
      end
      checks++;
      if (grant !== exp_grant) begin
        errors++; $display("FAIL contend_grant c=%0d got=%b exp=%b", c, grant, exp_grant);
      end
      if (c == 29) s_req = 2'b00;
    end
  endtask

  task automatic test_early_ready();
    int pulses;
    logic [1:0] exp_ack;
    pulses = 0;
    tick();
    s_req = 2'b01; m_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (m_transfer) pulses++;
      exp_ack = (c == 4) ? 2'b01 : 2'b00;
      checks++;
      if (s_ack !== exp_ack) begin
        errors++; $display("FAIL early_ack c=%0d got=%b exp=%b", c, s_ack, exp_ack);
      end
      if (c == 4) s_req = 2'b00;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL early_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_reset_in_access();
    tick();
    s_req = 2'b01; s_addr[0] = 32'h2000_0010; s_wdata[0] = 32'hCAFE_0001; s_write = 2'b01;
    m_ready = 1'b0;
    for (int c = 1; c <= 5; c++) tick();
    checks++;
    if ({busy, grant, s_ack} !== 5'b10100) begin
      errors++; $display("FAIL stall_state got=%b exp=10100", {busy, grant, s_ack});
    end
    #3;
    PRESET = 1'b1;
    #1;
    checks++;
    if ({m_transfer, m_write, busy, s_ack, grant} !== 7'b0) begin
      errors++; $display("FAIL areset_ctrl got=%b exp=0000000", {m_transfer, m_write, busy, s_ack, grant});
    end
    checks++;
    if ({m_addr, m_wdata, s_rdata} !== 96'h0) begin
      errors++; $display("FAIL areset_data got=%h %h %h exp=0", m_addr, m_wdata, s_rdata);
    end
    tick();
    PRESET = 1'b0;
    run_pair("post_reset");
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_tie_after_reset();
    test_contention();
    test_early_ready();
    test_reset_in_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
